// File: rtl/ram_port_ctrl.sv
// ============================================================================
// ram_port_ctrl : CPU load/store port to a single-port RAM with clear sweep
// Rev 1.0 : initial release
// ============================================================================
`default_nettype none

module ram_port_ctrl #(
  parameter int ADDR_WIDTH = 10,
  parameter int DATA_WIDTH = 32
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [31:0]           cpu_addr,
  input  logic                  cpu_re,
  input  logic                  cpu_we,
  input  logic [1:0]            cpu_size,
  input  logic                  cpu_unsigned,
  input  logic [31:0]           cpu_wdata,
  output logic [31:0]           cpu_rdata,
  output logic                  stall,
  output logic                  misalign,
  output logic                  init_done,
  output logic [ADDR_WIDTH-1:0] ram_addr,
  output logic                  ram_we,
  output logic [DATA_WIDTH-1:0] ram_d,
  input  logic [DATA_WIDTH-1:0] ram_q
);

  typedef enum logic [1:0] {
    CLEAR  = 2'd0,
    RUN    = 2'd1,
    RMW_WR = 2'd2
  } state_t;

  state_t                state, state_nx;
  logic [ADDR_WIDTH-1:0] cnt;
  logic [31:0]           merge, merge_nx;
  logic                  rmw_load;

  logic [ADDR_WIDTH-1:0] word_idx;
  logic                  size_word, size_half, size_byte;
  logic                  req, bad_align;
  logic [7:0]            ld_byte;
  logic [15:0]           ld_half;
  logic [31:0]           ld_data;
  logic                  unused_addr_bits;

  assign word_idx         = cpu_addr[ADDR_WIDTH+1:2];
  assign unused_addr_bits = ^cpu_addr[31:ADDR_WIDTH+2];

  // size 11 decodes as word
  assign size_word = cpu_size[1];
  assign size_half = (cpu_size == 2'b01);
  assign size_byte = (cpu_size == 2'b00);
  assign req       = cpu_re | cpu_we;
  assign bad_align = (size_half & cpu_addr[0]) | (size_word & (cpu_addr[1:0] != 2'b00));

  always_comb begin
    ld_byte = 8'h00;
    case (cpu_addr[1:0])
      2'd0:    ld_byte = ram_q[7:0];
      2'd1:    ld_byte = ram_q[15:8];
      2'd2:    ld_byte = ram_q[23:16];
      default: ld_byte = ram_q[31:24];
    endcase
    ld_half = cpu_addr[1] ? ram_q[31:16] : ram_q[15:0];
    if (size_word)
      ld_data = ram_q;
    else if (size_half)
      ld_data = {{16{~cpu_unsigned & ld_half[15]}}, ld_half};
    else
      ld_data = {{24{~cpu_unsigned & ld_byte[7]}}, ld_byte};
  end

  // Current RAM word with the addressed lane(s) replaced by the store data
  always_comb begin
    merge_nx = ram_q;
    if (size_byte) begin
      case (cpu_addr[1:0])
        2'd0:    merge_nx[7:0]   = cpu_wdata[7:0];
        2'd1:    merge_nx[15:8]  = cpu_wdata[7:0];
        2'd2:    merge_nx[23:16] = cpu_wdata[7:0];
        default: merge_nx[31:24] = cpu_wdata[7:0];
      endcase
    end else if (cpu_addr[1]) begin
      merge_nx[31:16] = cpu_wdata[15:0];
    end else begin
      merge_nx[15:0] = cpu_wdata[15:0];
    end
  end

  always_comb begin
    state_nx  = state;
    rmw_load  = 1'b0;
    ram_we    = 1'b0;
    ram_d     = '0;
    ram_addr  = word_idx;
    stall     = 1'b0;
    misalign  = 1'b0;
    cpu_rdata = 32'h0;
    init_done = 1'b0;
    if (rst) begin
      stall = 1'b1;
    end else begin
      case (state)
        CLEAR: begin
          ram_we   = 1'b1;
          ram_addr = cnt;
          stall    = 1'b1;
          if (cnt == {ADDR_WIDTH{1'b1}})
            state_nx = RUN;
        end
        RUN: begin
          init_done = 1'b1;
          if (req) begin
            if (bad_align) begin
              misalign = 1'b1;
            end else if (cpu_re) begin
              cpu_rdata = ld_data;
            end else if (size_word) begin
              ram_we = 1'b1;
              ram_d  = cpu_wdata;
            end else begin
              stall    = 1'b1;
              rmw_load = 1'b1;
              state_nx = RMW_WR;
            end
          end
        end
        RMW_WR: begin
          init_done = 1'b1;
          ram_we    = 1'b1;
          ram_d     = merge;
          state_nx  = RUN;
        end
        default: state_nx = CLEAR;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state <= CLEAR;
      cnt   <= '0;
      merge <= 32'h0;
    end else begin
      state <= state_nx;
      if (state == CLEAR)
        cnt <= cnt + 1'b1;
      if (rmw_load)
        merge <= merge_nx;
    end
  end

endmodule

`default_nettype wire
